// File: rtl/controller_pkg.sv
// Shared widths, bit positions and button typedef for the controller input path.
// Used by controller_input_processor and input_debouncer.
package controller_pkg;

  localparam int STATE_W = 7;
  localparam int BTN_W   = 6;

  // State-word bit positions
  localparam int IDX_CENTER = 0;
  localparam int IDX_LEFT   = 1;
  localparam int IDX_RIGHT  = 2;
  localparam int IDX_UP     = 3;
  localparam int IDX_DOWN   = 4;
  localparam int IDX_ATTACK = 5;
  localparam int IDX_PARRY  = 6;

  localparam logic [STATE_W-1:0] CENTER = 7'b0000001;
  localparam logic [STATE_W-1:0] LEFT   = 7'b0000010;
  localparam logic [STATE_W-1:0] RIGHT  = 7'b0000100;
  localparam logic [STATE_W-1:0] UP     = 7'b0001000;
  localparam logic [STATE_W-1:0] DOWN   = 7'b0010000;

  // Raw-bus positions within one player's 6-bit slice
  localparam int RAW_LEFT   = 0;
  localparam int RAW_RIGHT  = 1;
  localparam int RAW_UP     = 2;
  localparam int RAW_DOWN   = 3;
  localparam int RAW_ATTACK = 4;
  localparam int RAW_PARRY  = 5;

  // Active-high pressed view of one player's slice, same bit order as the raw bus
  typedef struct packed {
    logic parry;
    logic attack;
    logic down;
    logic up;
    logic right;
    logic left;
  } btn_t;

  function automatic logic [STATE_W-1:0] with_center(input logic [STATE_W-1:0] w);
    logic [STATE_W-1:0] r;
    r = w;
    r[IDX_CENTER] = (w[IDX_DOWN:IDX_LEFT] == 4'b0000);
    return r;
  endfunction

endpackage

// File: rtl/controller_input_debouncer.sv
// One active-low line: 2-flop synchroniser then a saturating-free counter debouncer.
// stable_l follows the synchronised input after DEBOUNCE_CYCLES agreeing clocks; press_pulse marks stable 1->0.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_l,
  output logic stable_l,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      stable_l    <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw_l;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 == stable_l) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // The clock that would reach DEBOUNCE_CYCLES accepts the change instead
        cnt         <= '0;
        stable_l    <= sync2;
        press_pulse <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/controller_input_processor.sv
// Per-player debounce and encode of active-low controller lines into a registered 7-bit word plus press pulses.
// Latency DEBOUNCE_CYCLES+2 clocks from capture; define CTRL_DIAGONAL_EN for diagonal direction encoding.
module controller_input_processor
  import controller_pkg::*;
#(
  parameter int N_PLAYERS       = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PLAYERS*6-1:0] btn_l,
  output logic [N_PLAYERS*7-1:0] state_out,
  output logic [N_PLAYERS-1:0]   attack_pulse,
  output logic [N_PLAYERS-1:0]   parry_pulse
);

  logic [N_PLAYERS*BTN_W-1:0]   stable_l;
  logic [N_PLAYERS-1:0]         attack_press;
  logic [N_PLAYERS-1:0]         parry_press;
  logic [N_PLAYERS*STATE_W-1:0] state_nxt;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    for (genvar b = 0; b < BTN_W; b++) begin : g_line
      logic press;

      input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk        (clk),
        .reset      (reset),
        .raw_l      (btn_l[p*BTN_W + b]),
        .stable_l   (stable_l[p*BTN_W + b]),
        .press_pulse(press)
      );

      if (b == RAW_ATTACK) begin : g_atk
        assign attack_press[p] = press;
      end else if (b == RAW_PARRY) begin : g_par
        assign parry_press[p] = press;
      end else begin : g_dir
        logic unused_press;
        assign unused_press = press;
      end
    end
  end

  function automatic logic [STATE_W-1:0] encode(input btn_t b);
    logic [STATE_W-1:0] w;
    w = '0;
`ifdef CTRL_DIAGONAL_EN
    // Opposing pairs cancel; horizontal and vertical combine freely
    if (b.left && !b.right)      w[IDX_LEFT]  = 1'b1;
    else if (b.right && !b.left) w[IDX_RIGHT] = 1'b1;
    if (b.up && !b.down)         w[IDX_UP]    = 1'b1;
    else if (b.down && !b.up)    w[IDX_DOWN]  = 1'b1;
`else
    if (b.left)       w = LEFT;
    else if (b.right) w = RIGHT;
    else if (b.up)    w = UP;
    else if (b.down)  w = DOWN;
`endif
    w[IDX_ATTACK] = b.attack;
    w[IDX_PARRY]  = b.parry;
    return with_center(w);
  endfunction

  always_comb begin
    state_nxt = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      state_nxt[p*STATE_W +: STATE_W] = encode(btn_t'(~stable_l[p*BTN_W +: BTN_W]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_out    <= {N_PLAYERS{CENTER}};
      attack_pulse <= '0;
      parry_pulse  <= '0;
    end else begin
      state_out    <= state_nxt;
      attack_pulse <= attack_press;
      parry_pulse  <= parry_press;
    end
  end

endmodule

// File: tb/tb_controller_input_processor.sv
// Directed bench for controller_input_processor (2 players, 4-cycle debounce) with an expectation queue.
module tb_controller_input_processor;
  import controller_pkg::*;

  localparam int NP = 2;
  localparam int DB = 4;

  localparam logic [5:0] B_L = 6'b000001;
  localparam logic [5:0] B_R = 6'b000010;
  localparam logic [5:0] B_U = 6'b000100;
  localparam logic [5:0] B_D = 6'b001000;
  localparam logic [5:0] B_A = 6'b010000;
  localparam logic [5:0] B_P = 6'b100000;

  localparam logic [6:0] W_C   = 7'b0000001;
  localparam logic [6:0] W_L   = 7'b0000010;
  localparam logic [6:0] W_R   = 7'b0000100;
  localparam logic [6:0] W_DN  = 7'b0010000;
  localparam logic [6:0] W_ATK = 7'b0100001;
  localparam logic [6:0] W_PAR = 7'b1000001;
  localparam logic [6:0] W_AP  = 7'b1100001;
`ifdef CTRL_DIAGONAL_EN
  localparam logic [6:0] W_LR = 7'b0000001;
  localparam logic [6:0] W_UL = 7'b0001010;
  localparam logic [6:0] W_UD = 7'b0000001;
`else
  localparam logic [6:0] W_LR = 7'b0000010;
  localparam logic [6:0] W_UL = 7'b0000010;
  localparam logic [6:0] W_UD = 7'b0001000;
`endif
  localparam logic [13:0] RST = {W_C, W_C};

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NP*BTN_W-1:0]   btn_l;
  logic [NP*STATE_W-1:0] state_out;
  logic [NP-1:0]         attack_pulse;
  logic [NP-1:0]         parry_pulse;

  typedef struct {
    logic [13:0] st;
    logic [1:0]  atk;
    logic [1:0]  par;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks = 0;
  int    errors = 0;

  controller_input_processor #(
    .N_PLAYERS      (NP),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_l       (btn_l),
    .state_out   (state_out),
    .attack_pulse(attack_pulse),
    .parry_pulse (parry_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [13:0] st, input logic [1:0] a, input logic [1:0] p);
    exp_t e;
    e.st  = st;
    e.atk = a;
    e.par = p;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic check_pop();
    exp_t  e;
    string tag;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got %0d entries required >0", sb.size());
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      tag = tags.pop_front();
      checks++;
      assert (state_out === e.st) else begin
        errors++;
        $error("FAIL %s state_out got %b required %b", tag, state_out, e.st);
      end
      checks++;
      assert (attack_pulse === e.atk) else begin
        errors++;
        $error("FAIL %s attack_pulse got %b required %b", tag, attack_pulse, e.atk);
      end
      checks++;
      assert (parry_pulse === e.par) else begin
        errors++;
        $error("FAIL %s parry_pulse got %b required %b", tag, parry_pulse, e.par);
      end
    end
  endtask

  // Drive a new pressed set; expect the old word for DB+2 clocks, the new word with pulses, then no pulses
  task automatic apply(input string tag, input logic [5:0] p1, input logic [5:0] p0,
                       input logic [13:0] old_w, input logic [13:0] new_w,
                       input logic [1:0] a, input logic [1:0] p);
    btn_l = ~{p1, p0};
    for (int i = 0; i < DB + 2; i++) push(tag, old_w, 2'b00, 2'b00);
    push(tag, new_w, a, p);
    push(tag, new_w, 2'b00, 2'b00);
    for (int i = 0; i < DB + 4; i++) begin
      tick();
      check_pop();
    end
  endtask

  initial begin
    // Asynchronous reset while random lines are applied
    reset = 1'b0;
    btn_l = 12'($urandom);
    repeat (20) tick();
    reset = 1'b1;
    #1;
    push("reset_async", RST, 2'b00, 2'b00);
    check_pop();
    btn_l = '1;
    for (int i = 0; i < 3; i++) begin
      push("reset_held", RST, 2'b00, 2'b00);
      tick();
      check_pop();
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("idle", RST, 2'b00, 2'b00);
      tick();
      check_pop();
    end

    // P0 left: not visible before edge k+6
    apply("p0_left", 6'b0, B_L, RST, {W_C, W_L}, 2'b00, 2'b00);
    apply("p0_left_rel", 6'b0, 6'b0, {W_C, W_L}, RST, 2'b00, 2'b00);

    // 3-clock attack glitch is rejected
    btn_l = ~{6'b0, B_A};
    for (int i = 0; i < 12; i++) begin
      if (i == 3) btn_l = '1;
      push("glitch3", RST, 2'b00, 2'b00);
      tick();
      check_pop();
    end

    // 4-clock attack glitch is accepted, then released
    btn_l = ~{6'b0, B_A};
    for (int t = 1; t <= 14; t++) begin
      if (t == 5) btn_l = '1;
      push("glitch4", (t >= 7 && t <= 10) ? {W_C, W_ATK} : RST,
           (t == 7) ? 2'b01 : 2'b00, 2'b00);
      tick();
      check_pop();
    end

    // Attack held 100 clocks: one pulse, no pulse on release
    apply("p0_atk_press", 6'b0, B_A, RST, {W_C, W_ATK}, 2'b01, 2'b00);
    for (int i = 0; i < 92; i++) begin
      push("p0_atk_hold", {W_C, W_ATK}, 2'b00, 2'b00);
      tick();
      check_pop();
    end
    apply("p0_atk_rel", 6'b0, 6'b0, {W_C, W_ATK}, RST, 2'b00, 2'b00);

    // Direction encoding on P1 and P0
    apply("p1_left_right", B_L | B_R, 6'b0, RST, {W_LR, W_C}, 2'b00, 2'b00);
    apply("p1_up_left", B_U | B_L, 6'b0, {W_LR, W_C}, {W_UL, W_C}, 2'b00, 2'b00);
    apply("p1_to_right", B_R, 6'b0, {W_UL, W_C}, {W_R, W_C}, 2'b00, 2'b00);
    apply("p0_up_down", 6'b0, B_U | B_D, {W_R, W_C}, {W_C, W_UD}, 2'b00, 2'b00);
    apply("p0_down", 6'b0, B_D, {W_C, W_UD}, {W_C, W_DN}, 2'b00, 2'b00);
    apply("p0_down_rel", 6'b0, 6'b0, {W_C, W_DN}, RST, 2'b00, 2'b00);

    // P1 attack and parry together
    apply("p1_atk_par", B_A | B_P, 6'b0, RST, {W_AP, W_C}, 2'b10, 2'b10);
    apply("p1_atk_par_rel", 6'b0, 6'b0, {W_AP, W_C}, RST, 2'b00, 2'b00);

    // Reset mid-debounce with parry still held
    btn_l = ~{6'b0, B_P};
    tick();
    tick();
    reset = 1'b1;
    #1;
    push("mid_reset_async", RST, 2'b00, 2'b00);
    check_pop();
    push("mid_reset_held", RST, 2'b00, 2'b00);
    tick();
    check_pop();
    reset = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      push("parry_after_reset", (t >= 7) ? {W_C, W_PAR} : RST, 2'b00,
           (t == 7) ? 2'b01 : 2'b00);
      tick();
      check_pop();
    end
    apply("p0_parry_rel", 6'b0, 6'b0, {W_C, W_PAR}, RST, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_input_processor.md
# controller_input_processor

Multi-player front end for the breadboard controllers. It synchronises, debounces and encodes raw active-low joystick and button lines into one registered 7-bit state word per player, plus single-cycle press pulses for attack and parry. It sits between the board pins and the game/fighter logic, and replaces direct LED-style decoding of undebounced pins.

## Interface

Parameters:
- `N_PLAYERS`, default 2: number of independent controllers; must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable clocks required to accept a change; must be ≥ 1. Board builds use 1_000_000, which is 10 ms at 100 MHz.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `btn_l`, input, `N_PLAYERS*6`: raw active-low lines. Player p occupies bits `[6p+5:6p]`, ordered {parry, attack, down, up, right, left}, with left at bit 6p.
- `state_out`, output, `N_PLAYERS*7`: registered state word. Player p occupies `[7p+6:7p]`. Bits: 0 CENTER, 1 LEFT, 2 RIGHT, 3 UP, 4 DOWN, 5 ATTACK, 6 PARRY.
- `attack_pulse`, output, `N_PLAYERS`: one-clock pulse on each accepted attack press.
- `parry_pulse`, output, `N_PLAYERS`: one-clock pulse on each accepted parry press.

## Operation

- **Synchroniser.** Each raw line passes through a two-flop synchroniser.
- **Debouncer.** Each synchronised line has its own debouncer, holding a stable value and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synchronised value differs from the stable value, the counter increments.
  - When they agree, the counter clears to 0.
  - When the counter would reach `DEBOUNCE_CYCLES`, the stable value flips and the counter clears in the same clock.
  - The counter never wraps. Any glitch shorter than `DEBOUNCE_CYCLES` clocks is fully rejected.
- **Pressed.** A line counts as pressed when its stable value is 0.
- **Direction encoding (default).** Priority is left > right > up > down. At most one of bits 1–4 is set.
- **CENTER.** Bit 0 is set exactly when bits 1–4 are all 0.
- **Attack and parry.** Bits 5 and 6 mirror the stable pressed state, independent of direction.
- **Pulses.** `attack_pulse[p]` and `parry_pulse[p]` assert for one clock on the stable released→pressed transition only. Releases and held buttons generate nothing.
- **Player independence.** Players are fully independent. No shared counters, no cross-player priority.

Reset state (asynchronous, all flops):
- Synchroniser and stable values: 1 (released).
- Counters: 0.
- `state_out`: 7'b0000001 per player.
- Pulses: 0.

## Timing

- A raw change captured at edge k appears on `state_out` and the pulses after edge k + `DEBOUNCE_CYCLES` + 2. With the default, that is edge k+6.
- All outputs are registered. There is no combinational path from `btn_l` to any output.
- Pulses are coincident with the `state_out` bit change they correspond to.
- **Reset asserted mid-debounce:** outputs go to reset values immediately. After release, a line still held low needs a full 2 + `DEBOUNCE_CYCLES` + 1 edges before it appears, and its press pulse fires at that point.
- **Simultaneous changes** on several lines of one player debounce independently. The encoded word reflects whatever stable values exist at each edge.
- **Direction change without release** (for example stable left→right in one edge) updates bits 1–4 in one clock, with CENTER staying 0.

## Configuration

`CTRL_DIAGONAL_EN` changes direction encoding only; the synchroniser, debouncer, ATTACK/PARRY bits and pulses are identical either way.

- **Undefined:** the priority one-hot encoding above.
- **Defined:** diagonals are allowed.
  - Left and right both pressed cancel: both bits 1 and 2 read 0.
  - Up and down both pressed cancel in the same way (bits 3 and 4).
  - Otherwise the horizontal bit and the vertical bit are set independently, so up+left gives 7'b0001010.
  - CENTER is still set exactly when bits 1–4 are 0.

## Structure

- **Package `controller_pkg`.**
  - Bit-index constants IDX_CENTER..IDX_PARRY.
  - One-hot constants CENTER/LEFT/RIGHT/UP/DOWN, 7 bits.
  - STATE_W = 7 and BTN_W = 6.
  - Raw-bus index constants for left..parry.
- **Sub-module `input_debouncer`.** Holds the synchroniser, counter, stable value and press-edge output, parametrised by `DEBOUNCE_CYCLES`. There is one instance per raw line, generated with `N_PLAYERS*6` instances.
- **Top level.** Encoding and the output registers stay in `controller_input_processor`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=4 and `N_PLAYERS`=2.

1. Assert `reset` with random `btn_l` → `state_out` = {7'b0000001, 7'b0000001} and pulses 0, asynchronously before the next clock edge.
2. P0 left held low from edge k → `state_out[6:0]` = 7'b0000010 after edge k+6 and never earlier. P1 is unchanged.
3. P0 attack glitches low for 3 clocks, then high → no state change and no `attack_pulse`. The same glitch held for 4 clocks is accepted.
4. P0 attack held 100 clocks → `state_out[5]` = 1 for that duration, `attack_pulse[0]` high for exactly 1 clock, and no pulse on release.
5. P1 left and right pressed together → 7'b0000010 without the macro. With `CTRL_DIAGONAL_EN`, 7'b0000001. Up+left with the macro gives 7'b0001010.
6. `reset` pulsed 2 clocks after P0 parry goes low while the button stays held → word resets, then 7'b1000001 appears after 7 edges past reset release, together with one `parry_pulse[0]`.
